// File: rtl/snn_ctrl_if.sv
// -----------------------------------------------------------------------------
// snn_ctrl_if: bundles every non-clock/reset signal of snn_ctrl.
//
// Handshake semantics (all signals synchronous to clk):
//   rx_rdy / clr_rx_rdy : rx_rdy is a level "byte pending" flag from the UART
//                         receiver. A byte is transferred on a rising clk edge
//                         where rx_rdy and clr_rx_rdy are both high.
//                         clr_rx_rdy is a one-cycle acknowledge asserted only
//                         while the controller is idle. A pending byte is
//                         otherwise left untouched in the UART.
//   snn_start / snn_done: snn_start is a one-cycle request; snn_done is a level
//                         that is sampled on every clock while the core runs.
//                         digit must be valid whenever snn_done is high.
//   tx_start / tx_done  : tx_start is a one-cycle request with tx_data valid
//                         from that cycle until the next request. tx_done can
//                         be a pulse or a level and is sampled only while the
//                         controller waits for the transmitter.
//
// Modports: master = controller side (snn_ctrl), slave = environment side.
// -----------------------------------------------------------------------------
interface snn_ctrl_if #(
  parameter int ADDR_W = 10
);
  logic              rx_rdy;
  logic [7:0]        rx_data;
  logic              clr_rx_rdy;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_data;
  logic [ADDR_W-1:0] snn_addr;
  logic              snn_start;
  logic              snn_done;
  logic [3:0]        digit;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_done;
  logic [3:0]        result;
  logic              busy;

  modport master (
    input  rx_rdy, rx_data, snn_addr, snn_done, digit, tx_done,
    output clr_rx_rdy, ram_we, ram_addr, ram_data, snn_start,
           tx_start, tx_data, result, busy
  );

  modport slave (
    output rx_rdy, rx_data, snn_addr, snn_done, digit, tx_done,
    input  clr_rx_rdy, ram_we, ram_addr, ram_data, snn_start,
           tx_start, tx_data, result, busy
  );
endinterface

// File: rtl/snn_ctrl.sv
// -----------------------------------------------------------------------------
// snn_ctrl: top-level sequencer for one SNN inference pass.
//
// Flow: receive NUM_BYTES UART bytes and write them bit by bit (LSB first)
// into the 1-bit input-unit RAM; pulse snn_start; hand the RAM read address
// to the core (snn_addr) until snn_done; send the guessed digit as one ASCII
// byte ('0'..'9', '?' for digit > 9) and wait for the transmitter.
//
// Ports:
//   clk        system clock
//   rst        asynchronous, active-high reset
//   bus        snn_ctrl_if.master (UART rx/tx, input RAM, snn_core handshake,
//              result display, busy)
//   dbg_state  current FSM state encoding (observation only)
//
// Optional feature (macro SNN_CTRL_TIMEOUT_EN): a watchdog on the snn_done
// wait. After TIMEOUT_CYCLES RUN cycles without snn_done the controller
// transmits 'E' and leaves result unchanged. Without the macro RUN waits
// indefinitely.
// -----------------------------------------------------------------------------
module snn_ctrl #(
  parameter int NUM_BYTES      = 98,
  parameter int ADDR_W         = 10,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic              clk,
  input  logic              rst,
  snn_ctrl_if.master        bus,
  output logic [2:0]        dbg_state
);

  localparam int BYTE_W = $clog2(NUM_BYTES);

  typedef enum logic [2:0] {
    S_RX_WAIT = 3'd0,
    S_WRITE   = 3'd1,
    S_START   = 3'd2,
    S_RUN     = 3'd3,
    S_TX      = 3'd4,
    S_TX_WAIT = 3'd5
  } state_t;

  state_t            state, state_nx;
  logic [BYTE_W-1:0] byte_cnt;
  logic [2:0]        bit_cnt;
  logic [7:0]        shreg;
  logic [3:0]        result_q;
  logic [7:0]        tx_data_q;
  logic              timeout_hit;
  logic              last_byte;
  logic              last_bit;

  assign last_byte = (byte_cnt == BYTE_W'(NUM_BYTES - 1));
  assign last_bit  = (bit_cnt == 3'd7);

`ifdef SNN_CTRL_TIMEOUT_EN
  logic [16:0] wdog;

  // Cleared in START so the first RUN cycle sees zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog <= '0;
    end else if (state == S_START) begin
      wdog <= '0;
    end else if (state == S_RUN) begin
      wdog <= wdog + 17'd1;
    end
  end

  assign timeout_hit = (state == S_RUN) && (wdog == 17'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // ASCII code of a digit; anything above 9 is reported as '?'.
  function automatic logic [7:0] digit_ascii(input logic [3:0] d);
    return (d <= 4'd9) ? (8'h30 + {4'h0, d}) : 8'h3F;
  endfunction

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_RX_WAIT;
    end else begin
      state <= state_nx;
    end
  end

  // Next state and combinational outputs
  always_comb begin
    state_nx       = state;
    bus.clr_rx_rdy = 1'b0;
    bus.ram_we     = 1'b0;
    bus.ram_addr   = '0;
    bus.ram_data   = 1'b0;
    bus.snn_start  = 1'b0;
    bus.tx_start   = 1'b0;
    case (state)
      S_RX_WAIT: begin
        if (bus.rx_rdy) begin
          bus.clr_rx_rdy = 1'b1;
          state_nx       = S_WRITE;
        end
      end
      S_WRITE: begin
        bus.ram_we   = 1'b1;
        // byte_cnt*8 + bit_cnt is a plain concatenation
        bus.ram_addr = ADDR_W'({byte_cnt, bit_cnt});
        bus.ram_data = shreg[0];
        if (last_bit) begin
          state_nx = last_byte ? S_START : S_RX_WAIT;
        end
      end
      S_START: begin
        bus.snn_start = 1'b1;
        bus.ram_addr  = bus.snn_addr;
        state_nx      = S_RUN;
      end
      S_RUN: begin
        bus.ram_addr = bus.snn_addr;
        if (bus.snn_done || timeout_hit) begin
          state_nx = S_TX;
        end
      end
      S_TX: begin
        bus.tx_start = 1'b1;
        state_nx     = S_TX_WAIT;
      end
      S_TX_WAIT: begin
        if (bus.tx_done) begin
          state_nx = S_RX_WAIT;
        end
      end
      default: state_nx = S_RX_WAIT;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      result_q  <= '0;
      tx_data_q <= '0;
    end else begin
      case (state)
        S_RX_WAIT: begin
          if (bus.rx_rdy) begin
            shreg <= bus.rx_data;
          end
        end
        S_WRITE: begin
          shreg <= {1'b0, shreg[7:1]};
          if (last_bit) begin
            bit_cnt  <= '0;
            byte_cnt <= last_byte ? '0 : byte_cnt + 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 3'd1;
          end
        end
        S_RUN: begin
          // snn_done has priority over a watchdog expiry in the same cycle
          if (bus.snn_done) begin
            result_q  <= bus.digit;
            tx_data_q <= digit_ascii(bus.digit);
          end else if (timeout_hit) begin
            tx_data_q <= 8'h45;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.result  = result_q;
  assign bus.tx_data = tx_data_q;
  assign bus.busy    = (state != S_RX_WAIT);
  assign dbg_state   = state;

endmodule

// File: tb/tb_snn_ctrl.sv
module tb_snn_ctrl;
  localparam int NUM_BYTES = 98;
  localparam int ADDR_W    = 10;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] dbg_state;
  int         cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  snn_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  snn_ctrl #(
    .NUM_BYTES(NUM_BYTES),
    .ADDR_W(ADDR_W),
    .TIMEOUT_CYCLES(65536)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [ADDR_W:0] exp_q[$];     // expected RAM writes {addr, data}
  logic [11:0]     tx_exp_q[$];  // expected transmit {result, tx_data}
  logic [ADDR_W:0] wr_e;
  logic [11:0]     tx_e;
  int              accept_cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Reference: image bit i of byte n lands at address n*8+i
  task automatic expect_byte(input int idx, input logic [7:0] b);
    logic [ADDR_W-1:0] a;
    for (int i = 0; i < 8; i++) begin
      a = ADDR_W'(idx * 8 + i);
      exp_q.push_back({a, b[i]});
    end
  endtask

  function automatic logic [7:0] exp_ascii(input logic [3:0] d);
    return (d < 4'd10) ? (8'h30 + 8'(d)) : 8'h3F;
  endfunction

  // Monitor: compares every RAM write and every transmit request
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.ram_we) begin
        if (exp_q.size() == 0) begin
          fail_now("ram_write_unexpected");
        end else begin
          wr_e = exp_q.pop_front();
          chk("ram_write", 32'({bus.ram_addr, bus.ram_data}), 32'(wr_e));
        end
      end
      if (bus.tx_start) begin
        if (tx_exp_q.size() == 0) begin
          fail_now("tx_unexpected");
        end else begin
          tx_e = tx_exp_q.pop_front();
          chk("tx_data", 32'(bus.tx_data), 32'(tx_e[7:0]));
          chk("result_at_tx", 32'(bus.result), 32'(tx_e[11:8]));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input int idx, input logic [7:0] b);
    bit got;
    expect_byte(idx, b);
    @(posedge clk); #1;
    bus.rx_data = b;
    bus.rx_rdy  = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (bus.clr_rx_rdy) begin
        got        = 1'b1;
        accept_cyc = cyc;
      end
    end
    if (!got) fail_now("rx_accept_timeout");
    // keep the byte pending for two WRITE cycles: it must not be acknowledged
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("clr_in_write", 32'(bus.clr_rx_rdy), 32'd0);
    end
    @(posedge clk); #1;
    bus.rx_rdy = 1'b0;
  endtask

  task automatic check_idle_outputs(input string name);
    chk({name, "_busy"}, 32'(bus.busy), 32'd0);
    chk({name, "_ram_we"}, 32'(bus.ram_we), 32'd0);
    chk({name, "_ram_addr"}, 32'(bus.ram_addr), 32'd0);
    chk({name, "_tx_data"}, 32'(bus.tx_data), 32'd0);
    chk({name, "_result"}, 32'(bus.result), 32'd0);
    chk({name, "_starts"}, 32'({bus.snn_start, bus.tx_start, bus.clr_rx_rdy}), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // mode 0: all zero, mode 1: A5 first / 80 last / random middle, mode 2: random
  task automatic run_image(input int mode, input logic [3:0] d, input bit done_early);
    logic [7:0]        b;
    logic [ADDR_W-1:0] sa;
    bit                got;
    int                n;
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (mode == 0)                        b = 8'h00;
      else if (mode == 1 && i == 0)         b = 8'hA5;
      else if (mode == 1 && i == NUM_BYTES-1) b = 8'h80;
      else                                  b = 8'($urandom_range(0, 255));
      if (i == NUM_BYTES - 1 && done_early) tx_exp_q.push_back({d, exp_ascii(d)});
      send_byte(i, b);
      if (i == NUM_BYTES - 1 && done_early) begin
        bus.digit    = d;
        bus.snn_done = 1'b1;
      end
    end
    got = 1'b0;
    for (int k = 0; k < 30 && !got; k++) begin
      @(negedge clk);
      if (bus.snn_start) got = 1'b1;
    end
    if (!got) fail_now("snn_start_timeout");
    else chk("start_latency", 32'(cyc - accept_cyc), 32'd9);
    if (!done_early) begin
      n = $urandom_range(3, 8);
      for (int k = 0; k < n; k++) begin
        @(posedge clk); #1;
        sa = (k == 0) ? 10'h2A7 : ADDR_W'($urandom_range(0, 1023));
        bus.snn_addr = sa;
        bus.rx_rdy   = 1'b1;
        bus.rx_data  = 8'($urandom_range(0, 255));
        @(negedge clk);
        chk("run_ram_addr", 32'(bus.ram_addr), 32'(sa));
        chk("run_ram_we", 32'(bus.ram_we), 32'd0);
        chk("run_no_clr", 32'(bus.clr_rx_rdy), 32'd0);
        chk("run_single_start", 32'(bus.snn_start), 32'd0);
      end
      tx_exp_q.push_back({d, exp_ascii(d)});
      @(posedge clk); #1;
      bus.rx_rdy   = 1'b0;
      bus.digit    = d;
      bus.snn_done = 1'b1;
    end
    got = 1'b0;
    for (int k = 0; k < 30 && !got; k++) begin
      @(negedge clk);
      if (bus.tx_start) got = 1'b1;
    end
    if (!got) fail_now("tx_start_timeout");
    @(posedge clk); #1;
    bus.snn_done = 1'b0;
    bus.digit    = 4'($urandom_range(0, 15));
    bus.snn_addr = 10'h155;
    n = $urandom_range(1, 4);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk("txwait_busy", 32'(bus.busy), 32'd1);
      chk("txwait_ram_addr", 32'(bus.ram_addr), 32'd0);
      chk("txwait_tx_held", 32'(bus.tx_data), 32'(exp_ascii(d)));
      chk("txwait_single_tx", 32'(bus.tx_start), 32'd0);
    end
    @(posedge clk); #1;
    bus.tx_done = 1'b1;
    @(posedge clk); #1;
    bus.tx_done = 1'b0;
    @(negedge clk);
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("idle_result", 32'(bus.result), 32'(d));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst          = 1'b1;
    bus.rx_rdy   = 1'b0;
    bus.rx_data  = 8'h00;
    bus.snn_addr = '0;
    bus.snn_done = 1'b0;
    bus.digit    = 4'h0;
    bus.tx_done  = 1'b0;
    do_reset();

    run_image(0, 4'd4, 1'b0);
    run_image(1, 4'($urandom_range(0, 9)), 1'b0);
    run_image(2, 4'hC, 1'b0);

    // abandon an image part-way: the next byte must start again at address 0
    for (int i = 0; i < 50; i++) send_byte(i, 8'($urandom_range(0, 255)));
    repeat (12) @(posedge clk);
    do_reset();
    run_image(2, 4'($urandom_range(0, 15)), 1'b1);

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("wr_queue_drained", 32'(exp_q.size()), 32'd0);
    chk("tx_queue_drained", 32'(tx_exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    fail_now("global_timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/snn_ctrl.md
Name: snn_ctrl

Overview:
- Top-level sequencer for one inference pass.
- Receives a 784-pixel binary image as 98 UART bytes and unpacks it bit-by-bit into the 1-bit input-unit RAM.
- Starts snn_core, then gives the core's addr_input_unit exclusive use of the RAM read port while it runs.
- On core completion, transmits the guessed digit as one ASCII byte through the UART transmitter.

Parameters:
- NUM_BYTES, 98, image bytes per inference (NUM_BYTES*8 = 784 input units).
- ADDR_W, 10, input RAM address width.
- TIMEOUT_CYCLES, 65536, watchdog limit on snn_done wait (used only with SNN_CTRL_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, 50MHz.
- rst  in  1  asynchronous, active-high reset.
- rx_rdy  in  1  UART receiver has a byte.
- rx_data  in  8  received byte.
- clr_rx_rdy  out  1  one-cycle pulse acknowledging rx byte.
- ram_we  out  1  input RAM write enable.
- ram_addr  out  ADDR_W  input RAM address (muxed).
- ram_data  out  1  input RAM write data.
- snn_addr  in  ADDR_W  addr_input_unit from snn_core.
- snn_start  out  1  one-cycle start pulse to snn_core.
- snn_done  in  1  snn_core done (level).
- digit  in  4  snn_core result.
- tx_start  out  1  one-cycle pulse to UART transmitter.
- tx_data  out  8  byte to transmit.
- tx_done  in  1  transmitter finished (pulse or level).
- result  out  4  last latched digit (LED display).
- busy  out  1  high in every state except RX_WAIT.

Behaviour:
- Reset: state RX_WAIT; byte_cnt=0, bit_cnt=0, shreg=0; all outputs 0 (ram_addr=0, tx_data=0, result=0).
- States: RX_WAIT, WRITE, START, RUN, TX, TX_WAIT.
- RX_WAIT:
  - On rx_rdy=1: shreg<=rx_data; clr_rx_rdy=1 in that same cycle; go to WRITE.
  - rx_rdy in any other state is ignored and not acknowledged; the byte stays pending in the UART.
- WRITE, exactly 8 cycles:
  - ram_we=1, ram_addr=byte_cnt*8+bit_cnt, ram_data=shreg[0].
  - shreg shifts right each cycle, so bit 0 is written first.
  - After bit_cnt==7: bit_cnt<=0. If byte_cnt==NUM_BYTES-1, go to START with byte_cnt<=0; else byte_cnt++ and go to RX_WAIT.
  - Final write address is 783.
- START: snn_start=1 for one cycle; ram_we=0; go to RUN.
- RUN:
  - ram_addr=snn_addr combinationally; ram_we=0.
  - On snn_done=1: result<=digit; go to TX.
- TX:
  - tx_start=1 for one cycle.
  - tx_data=8'h30+digit for digit 0..9; tx_data=8'h3F ('?') for digit>9.
  - tx_data is registered and held until the next TX.
  - Go to TX_WAIT.
- TX_WAIT: on tx_done=1, go to RX_WAIT.
- ram_addr mux: snn_addr in START and RUN; write address in WRITE; 0 elsewhere.
- Simultaneous rx_rdy and the WRITE→RX_WAIT transition: the byte is accepted on the first RX_WAIT cycle (one cycle later), never in WRITE.
- Reset mid-operation: returns to RX_WAIT with byte_cnt=0. The partial image is discarded; the next byte is treated as byte 0.
- snn_done already high on RUN entry is honoured on the first RUN cycle.
- Latency, last rx byte accepted to snn_start: 9 cycles (8 WRITE + START).

Optional Feature:
- Macro SNN_CTRL_TIMEOUT_EN.
- Defined:
  - 17-bit watchdog counter cleared on RUN entry, increments each RUN cycle.
  - If it reaches TIMEOUT_CYCLES-1 without snn_done: go to TX with tx_data=8'h45 ('E'); result unchanged.
  - snn_done on the same cycle as expiry wins: the normal digit is sent.
- Undefined: no counter; RUN waits indefinitely.

Test Plan:
- Reset, then 98 bytes of 8'h00 with the core model returning digit=4 → RAM addr 0..783 all written 0; one snn_start pulse 9 cycles after the last accept; tx_data=8'h34; result=4; busy falls after tx_done.
- Byte 0 = 8'hA5 → writes at addr 0..7 are 1,0,1,0,0,1,0,1; clr_rx_rdy high exactly one cycle; byte_cnt=1.
- Byte 97 = 8'h80 → addr 783 written 1 in the last WRITE cycle; no write beyond 783.
- In RUN, drive snn_addr=10'h2A7 → ram_addr=10'h2A7 the same cycle; ram_we=0; rx_rdy asserted during RUN gets no clr_rx_rdy.
- Core returns digit=4'hC → tx_data=8'h3F.
- Reset asserted after 50 bytes, then 98 fresh bytes → first post-reset byte written at addr 0..7; normal completion. With SNN_CTRL_TIMEOUT_EN and TIMEOUT_CYCLES=16, snn_done held low → tx_data=8'h45 exactly 16 cycles after RUN entry.
